// File: rtl/ppf_pkg.sv
// Shared types and helpers for the polyphase filter bank front end.
package ppf_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < value; v = v << 1)
            r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned DEFAULT_NUM_CH = 8;
    localparam int unsigned IDX_W          = clog2(DEFAULT_NUM_CH);

    localparam int unsigned COMMUTATE_FWD = 0;
    localparam int unsigned COMMUTATE_REV = 1;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } cplx_sample_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } ppf_state_t;

endpackage

// File: rtl/ppf_frame_collector.sv
// Commutator index, slot mapping and collect buffer for one polyphase frame.
module ppf_frame_collector
    import ppf_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned REVERSE     = COMMUTATE_FWD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          accept,
    input  logic                          flush,
    input  logic [TDATA_WIDTH-1:0]        sample,
    input  logic                          last,
    output logic                          close,
    output logic                          trunc,
    output logic [NUM_CH*TDATA_WIDTH-1:0] collect_q,
    output logic [NUM_CH*TDATA_WIDTH-1:0] merged
);

    localparam int unsigned CNT_W = clog2(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CH - 1);

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] slot;
    logic             at_last;

    always_comb begin
        at_last = (idx == LAST_IDX);
        slot    = (REVERSE == COMMUTATE_REV) ? (LAST_IDX - idx) : idx;
        close   = accept && (at_last || last);
        trunc   = last && !at_last;
    end

    // Buffer contents with the current beat already placed in its branch slot.
    always_comb begin
        merged = collect_q;
        merged[int'(slot)*TDATA_WIDTH +: TDATA_WIDTH] = sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            collect_q <= '0;
        end else begin
            if (accept)
                idx <= (at_last || last) ? '0 : idx + CNT_W'(1);
            if (flush)
                collect_q <= '0;
            else if (accept)
                collect_q <= merged;
        end
    end

endmodule

// File: rtl/s_axis_polyphase_demux.sv
// AXI-Stream slave that commutates serial samples into NUM_CH-wide PPF frames.
module s_axis_polyphase_demux
    import ppf_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned REVERSE     = COMMUTATE_FWD
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [TDATA_WIDTH-1:0]        TDATA,
    input  logic                          TVALID,
    input  logic                          TLAST,
    output logic                          TREADY,
    output logic [NUM_CH*TDATA_WIDTH-1:0] frame_o,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic                          frame_last_o,
    output logic                          frame_err_o
);

    ppf_state_t state;
    logic       hold_last;
    logic       hold_err;
    logic       slot_free;
    logic       accept;
    logic       flush;
    logic       close;
    logic       trunc;
    logic [NUM_CH*TDATA_WIDTH-1:0] collect_q;
    logic [NUM_CH*TDATA_WIDTH-1:0] merged;

    always_comb begin
        TREADY    = (state == COLLECT) && ARESETn;
        slot_free = !frame_valid_o || frame_ready_i;
        accept    = TVALID && TREADY;
        flush     = slot_free && ((state == COLLECT && close) || state == HOLD);
    end

    ppf_frame_collector #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .NUM_CH      (NUM_CH),
        .REVERSE     (REVERSE)
    ) u_collector (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .accept    (accept),
        .flush     (flush),
        .sample    (TDATA),
        .last      (TLAST),
        .close     (close),
        .trunc     (trunc),
        .collect_q (collect_q),
        .merged    (merged)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= COLLECT;
            hold_last     <= 1'b0;
            hold_err      <= 1'b0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            frame_last_o  <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (close && slot_free) begin
                        frame_o       <= merged;
                        frame_valid_o <= 1'b1;
                        frame_last_o  <= TLAST;
                        frame_err_o   <= trunc;
                    end else if (close) begin
                        // Output still occupied: the collector keeps the merged frame.
                        hold_last <= TLAST;
                        hold_err  <= trunc;
                        state     <= HOLD;
                    end else if (frame_ready_i) begin
                        frame_valid_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        frame_o       <= collect_q;
                        frame_valid_o <= 1'b1;
                        frame_last_o  <= hold_last;
                        frame_err_o   <= hold_err;
                        state         <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_s_axis_polyphase_demux.sv
// Scoreboard bench: forward and reversed commutator instances driven by one stream.
module tb_s_axis_polyphase_demux;
    import ppf_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned FW = N * W;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [W-1:0]  TDATA;
    logic          TVALID;
    logic          TLAST;
    logic          TREADY;
    logic          tready_rev;
    logic [FW-1:0] frame_o;
    logic [FW-1:0] frame_rev;
    logic          frame_valid_o, valid_rev;
    logic          frame_ready_i;
    logic          frame_last_o, last_rev;
    logic          frame_err_o, err_rev;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [FW-1:0] data;
        logic          last;
        logic          err;
    } exp_t;

    exp_t q_fwd[$];
    exp_t q_rev[$];
    logic [W-1:0] beats[N];
    int unsigned  cnt = 0;

    always #5 ACLK = ~ACLK;

    s_axis_polyphase_demux #(.TDATA_WIDTH(W), .NUM_CH(N), .REVERSE(COMMUTATE_FWD)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST),
        .TREADY(TREADY), .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .frame_last_o(frame_last_o), .frame_err_o(frame_err_o)
    );

    s_axis_polyphase_demux #(.TDATA_WIDTH(W), .NUM_CH(N), .REVERSE(COMMUTATE_REV)) dut_rev (
        .ACLK(ACLK), .ARESETn(ARESETn), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST),
        .TREADY(tready_rev), .frame_o(frame_rev), .frame_valid_o(valid_rev),
        .frame_ready_i(frame_ready_i), .frame_last_o(last_rev), .frame_err_o(err_rev)
    );

    // Scoreboard: every output handshake pops one expected frame per instance.
    always @(negedge ACLK) begin
        exp_t e;
        if (ARESETn && frame_valid_o && frame_ready_i) begin
            checks++;
            if (q_fwd.size() == 0) begin
                errors++;
                $display("FAIL fwd_unexpected_frame got %h", frame_o);
            end else begin
                e = q_fwd.pop_front();
                if (frame_o !== e.data || frame_last_o !== e.last || frame_err_o !== e.err) begin
                    errors++;
                    $display("FAIL fwd_frame got %h l%b e%b exp %h l%b e%b",
                             frame_o, frame_last_o, frame_err_o, e.data, e.last, e.err);
                end
            end
        end
        if (ARESETn && valid_rev && frame_ready_i) begin
            checks++;
            if (q_rev.size() == 0) begin
                errors++;
                $display("FAIL rev_unexpected_frame got %h", frame_rev);
            end else begin
                e = q_rev.pop_front();
                if (frame_rev !== e.data || last_rev !== e.last || err_rev !== e.err) begin
                    errors++;
                    $display("FAIL rev_frame got %h l%b e%b exp %h l%b e%b",
                             frame_rev, last_rev, err_rev, e.data, e.last, e.err);
                end
            end
        end
    end

    task automatic model_reset();
        cnt = 0;
        q_fwd.delete();
        q_rev.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic l);
        exp_t ef, er;
        beats[cnt] = d;
        cnt++;
        if (cnt == N || l) begin
            ef.data = '0;
            er.data = '0;
            for (int k = 0; k < int'(cnt); k++) begin
                ef.data[k*W +: W]       = beats[k];
                er.data[(N-1-k)*W +: W] = beats[k];
            end
            ef.last = l;
            ef.err  = l && (cnt < N);
            er.last = ef.last;
            er.err  = ef.err;
            q_fwd.push_back(ef);
            q_rev.push_back(er);
            cnt = 0;
        end
    endtask

    // Offers one beat; returns just after the accepting edge with the cycles it waited.
    task automatic send_beat(input logic [W-1:0] d, input logic l, output int waits);
        bit got = 0;
        waits = 0;
        TVALID = 1'b1;
        TDATA  = d;
        TLAST  = l;
        while (!got && waits < 200) begin
            @(negedge ACLK);
            if (TREADY) begin
                got = 1;
                model_accept(d, l);
            end
            @(posedge ACLK);
            #1;
            waits++;
        end
        TVALID = 1'b0;
        TLAST  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout data %h", d);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_fwd.size() != 0 || q_rev.size() != 0) && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        checks++;
        if (q_fwd.size() != 0 || q_rev.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending fwd %0d rev %0d exp 0", q_fwd.size(), q_rev.size());
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        TVALID = 1'b1;
        TDATA = 32'hDEAD_BEEF;
        TLAST = 1'b0;
        frame_ready_i = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (TREADY !== 1'b0 || frame_valid_o !== 1'b0 || frame_o !== '0 ||
            frame_last_o !== 1'b0 || frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values tready %b valid %b last %b err %b frame %h exp all 0",
                     TREADY, frame_valid_o, frame_last_o, frame_err_o, frame_o);
        end
        @(posedge ACLK);
        #1;
        TVALID = 1'b0;
        ARESETn = 1'b1;
        model_reset();
        @(negedge ACLK);
        checks++;
        if (TREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready got %b exp 1", TREADY);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_stream();
        int w;
        int slow = 0;
        frame_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send_beat(W'(i), i == 16, w);
            if (w != 1) slow++;
            if (i == 8) begin
                checks++;
                if (frame_valid_o !== 1'b1 || frame_o[0 +: W] !== 32'h1 ||
                    frame_o[7*W +: W] !== 32'h8 || frame_last_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency valid %b b0 %h b7 %h last %b exp 1 1 8 0",
                             frame_valid_o, frame_o[0 +: W], frame_o[7*W +: W], frame_last_o);
                end
            end
        end
        checks++;
        if (slow != 0) begin
            errors++;
            $display("FAIL stream_tready_drops got %0d stalled beats exp 0", slow);
        end
        checks++;
        if (frame_valid_o !== 1'b1 || frame_o[0 +: W] !== 32'h9 || frame_last_o !== 1'b1 ||
            frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_frame2 valid %b b0 %h last %b err %b exp 1 9 1 0",
                     frame_valid_o, frame_o[0 +: W], frame_last_o, frame_err_o);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w;
        logic [FW-1:0] snap;
        logic [FW-1:0] exp2;
        frame_ready_i = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            send_beat(32'h100 + W'(i), i == 16, w);
            if (i == 8) snap = frame_o;
        end
        checks++;
        if (TREADY !== 1'b0 || frame_valid_o !== 1'b1 || frame_o !== snap) begin
            errors++;
            $display("FAIL bp_hold tready %b valid %b frame %h exp 0 1 %h", TREADY, frame_valid_o, frame_o, snap);
        end
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (TREADY !== 1'b0 || frame_valid_o !== 1'b1 || frame_o !== snap || frame_last_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable tready %b valid %b last %b frame %h exp 0 1 0 %h",
                     TREADY, frame_valid_o, frame_last_o, frame_o, snap);
        end
        frame_ready_i = 1'b1;
        @(posedge ACLK);
        #1;
        for (int b = 0; b < int'(N); b++) exp2[b*W +: W] = 32'h109 + W'(b);
        checks++;
        if (frame_valid_o !== 1'b1 || frame_o !== exp2 || frame_last_o !== 1'b1 || TREADY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid %b last %b tready %b frame %h exp 1 1 1 %h",
                     frame_valid_o, frame_last_o, TREADY, frame_o, exp2);
        end
        wait_drain();
    endtask

    task automatic test_early_last();
        int w;
        cplx_sample_t s;
        frame_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(32'hA + W'(i), i == 4, w);
        s = frame_o[0 +: W];
        checks++;
        if (frame_valid_o !== 1'b1 || frame_err_o !== 1'b1 || frame_last_o !== 1'b1 ||
            s.re !== 16'h0 || s.im !== 16'hA || frame_o[4*W +: W] !== 32'hE ||
            frame_o[5*W +: 3*W] !== '0) begin
            errors++;
            $display("FAIL early_last valid %b err %b last %b frame %h exp 1 1 1 upper zero",
                     frame_valid_o, frame_err_o, frame_last_o, frame_o);
        end
        for (int i = 0; i < 8; i++) send_beat(32'h21 + W'(i), i == 7, w);
        checks++;
        if (frame_o[0 +: W] !== 32'h21 || frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL early_last_realign b0 %h err %b exp 21 0", frame_o[0 +: W], frame_err_o);
        end
        wait_drain();
    endtask

    task automatic test_reverse();
        int w;
        frame_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(W'(i), 1'b0, w);
        checks++;
        if (valid_rev !== 1'b1 || frame_rev[7*W +: W] !== 32'h1 || frame_rev[0 +: W] !== 32'h8) begin
            errors++;
            $display("FAIL reverse_order valid %b b7 %h b0 %h exp 1 1 8",
                     valid_rev, frame_rev[7*W +: W], frame_rev[0 +: W]);
        end
        wait_drain();
    endtask

    task automatic test_mid_reset();
        int w;
        frame_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(32'h51 + W'(i), 1'b0, w);
        ARESETn = 1'b0;
        model_reset();
        @(negedge ACLK);
        checks++;
        if (TREADY !== 1'b0 || frame_valid_o !== 1'b0 || frame_o !== '0) begin
            errors++;
            $display("FAIL midreset_values tready %b valid %b frame %h exp 0 0 0", TREADY, frame_valid_o, frame_o);
        end
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(32'h11 + W'(i), 1'b0, w);
        checks++;
        if (frame_o[0 +: W] !== 32'h11 || frame_o[7*W +: W] !== 32'h18) begin
            errors++;
            $display("FAIL midreset_frame b0 %h b7 %h exp 11 18", frame_o[0 +: W], frame_o[7*W +: W]);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_early_last();
        test_reverse();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axis_polyphase_demux.md
Name: s_axis_polyphase_demux

Overview:
- Parametrised AXI-Stream slave front end for the direct-form polyphase filter bank (PPF).
- Commutates a serial complex sample stream into NUM_CH polyphase branches. Packs each full commutator cycle into one wide frame word, sent on a valid/ready output port.
- Unlike the fixed 8-phase front end, it supports real TREADY backpressure, TLAST frame alignment, partial-frame detection and selectable commutator direction.
- Sits between the ADC/DMA AXIS source and the PPF branch filters.

Parameters:
- TDATA_WIDTH, 32, sample width; upper half is real, lower half is imaginary. Must be even.
- NUM_CH, 8, number of polyphase branches. Power of 2, range 2..64.
- REVERSE, 0, commutator order. 0: beat k of a frame goes to branch k. 1: beat k goes to branch NUM_CH-1-k (PPF commutator convention).

Ports:
- ACLK  in  1  AXIS clock; the only clock.
- ARESETn  in  1  asynchronous reset, active-low.
- TDATA  in  TDATA_WIDTH  input sample.
- TVALID  in  1  input beat valid.
- TLAST  in  1  last beat of packet.
- TREADY  out  1  block can accept a beat.
- frame_o  out  NUM_CH*TDATA_WIDTH  branch b occupies bits [b*TDATA_WIDTH +: TDATA_WIDTH].
- frame_valid_o  out  1  frame_o holds a complete frame.
- frame_ready_i  in  1  downstream accepts the frame.
- frame_last_o  out  1  frame ended on TLAST; qualified by frame_valid_o.
- frame_err_o  out  1  frame truncated by early TLAST; qualified by frame_valid_o.

Behaviour:
- Reset: one clock, ACLK; asynchronous active-low reset, ARESETn.
- Reset values:
  - TREADY=0 during reset, 1 on the first cycle after release.
  - frame_o=0, frame_valid_o=0, frame_last_o=0, frame_err_o=0.
  - Beat index=0, collect buffer=0, state=COLLECT.
- Beat acceptance: a beat is accepted when TVALID && TREADY. TREADY is registered-free: TREADY = (state==COLLECT) && ARESETn.
- Index and slot:
  - Index counter is $clog2(NUM_CH) bits.
  - Slot written = REVERSE ? NUM_CH-1-idx : idx.
  - idx increments per accepted beat. It returns to 0 after beat NUM_CH-1 or after any TLAST beat.
- Frame close: a frame closes on an accepted beat with idx==NUM_CH-1 or TLAST=1.
  - Early TLAST (idx<NUM_CH-1): unwritten slots stay 0 and frame_err_o=1 for that frame.
  - frame_last_o = TLAST of the closing beat.
- States:
  - COLLECT: accept beats. On a closing beat, if the output slot is free (!frame_valid_o || frame_ready_i), load the output registers from the collect buffer with the closing beat merged in, then clear the collect buffer; stay in COLLECT. Otherwise latch the closing beat into the buffer, latch last/err flags, and go to HOLD.
  - HOLD: TREADY=0. When (!frame_valid_o || frame_ready_i), transfer the buffer and flags to the output, clear the buffer, and return to COLLECT.
- Latency: closing beat accepted in cycle n gives frame_valid_o=1 in cycle n+1 (no backpressure).
- Throughput: with frame_ready_i held high, one beat per cycle indefinitely; TREADY never drops.
- Output handshake: while frame_valid_o && !frame_ready_i, frame_o/last/err are held stable. frame_valid_o clears on a handshake unless a new frame loads in the same cycle.
- Simultaneous events: an output handshake and a new frame load in the same cycle keeps frame_valid_o=1 with the new data.
- Backpressure worst case: at most 1 full frame buffered plus 1 on the output. TREADY drops only in HOLD.
- Mid-operation reset: asynchronous reset discards a partial frame and any held frame immediately. There is no output glitch beyond reset values.
- TVALID without TREADY: no state change. TDATA/TLAST are ignored.

Decomposition:
- Shared package ppf_pkg:
  - function clog2;
  - localparam IDX_W derived from NUM_CH;
  - typedef for a complex sample (re/im halves);
  - REVERSE encoding constants (COMMUTATE_FWD=0, COMMUTATE_REV=1).
- One natural sub-module: ppf_frame_collector. It holds the index counter, collect buffer and slot-mapping logic. The top keeps the COLLECT/HOLD FSM and output register.

Test Plan:
- Reset: hold ARESETn=0 while TVALID=1 -> TREADY=0, frame_valid_o=0, frame_o=0. Release -> TREADY=1 next cycle.
- Continuous stream, NUM_CH=8, frame_ready_i=1: 16 beats 0x0000_0001..0x0000_0010, TLAST on beat 16.
  - Frame 1 valid the cycle after beat 8, branch b = b+1, last=0.
  - Frame 2 = 9..16 with last=1, err=0. TREADY stays 1 throughout.
- Backpressure: frame_ready_i=0 while 16 beats are offered.
  - Frame 1 is held stable; frame 2 collects into HOLD; TREADY=0 from the cycle after beat 16.
  - Raise frame_ready_i: frame 2 appears the cycle after frame 1's handshake; TREADY=1 the cycle after.
- Early TLAST: 5 beats 0xA..0xE, TLAST on beat 5 -> frame with branches 0..4 = 0xA..0xE, branches 5..7 = 0, err=1, last=1. The next beat lands in branch 0.
- REVERSE=1: beats 1..8 -> branch 7 = 1 … branch 0 = 8.
- Mid-frame reset: 3 beats, then ARESETn=0 for 1 cycle, then beats 0x11..0x18 -> output frame = 0x11..0x18 with no residue from the first 3 beats.
